// File: rtl/seg_pkg.sv
// ---------------------------------------------------------------------------
// seg_pkg
// Shared definitions for the 7-segment scan driver:
//   - active-high hex glyphs, bit0 = segment a .. bit6 = segment g
//   - SEG_OFF, the active-high "all segments dark" pattern
//   - clog2_min1(), a counter width that never collapses to zero bits
// ---------------------------------------------------------------------------
package seg_pkg;

   localparam logic [6:0] GLYPH_0 = 7'h3F;
   localparam logic [6:0] GLYPH_1 = 7'h06;
   localparam logic [6:0] GLYPH_2 = 7'h5B;
   localparam logic [6:0] GLYPH_3 = 7'h4F;
   localparam logic [6:0] GLYPH_4 = 7'h66;
   localparam logic [6:0] GLYPH_5 = 7'h6D;
   localparam logic [6:0] GLYPH_6 = 7'h7D;
   localparam logic [6:0] GLYPH_7 = 7'h07;
   localparam logic [6:0] GLYPH_8 = 7'h7F;
   localparam logic [6:0] GLYPH_9 = 7'h67;
   localparam logic [6:0] GLYPH_A = 7'h77;
   localparam logic [6:0] GLYPH_B = 7'h7C;
   localparam logic [6:0] GLYPH_C = 7'h39;
   localparam logic [6:0] GLYPH_D = 7'h5E;
   localparam logic [6:0] GLYPH_E = 7'h79;
   localparam logic [6:0] GLYPH_F = 7'h71;

   localparam logic [6:0] SEG_OFF = 7'h00;

   // Bits needed to count 0..n-1; at least 1 so single-value counters stay legal.
   function automatic int clog2_min1(input int n);
      int w;
      w = 1;
      while ((32'sd1 << w) < n) begin
         w = w + 1;
      end
      return w;
   endfunction

endpackage : seg_pkg

// File: rtl/seg_hex_glyph.sv
// ---------------------------------------------------------------------------
// seg_hex_glyph
// Combinational hex-nibble to 7-segment glyph decoder (active-high).
// Ports:
//   nibble  in  4  hex digit 0..F
//   glyph   out 7  segments a..g, bit0 = a, 1 = lit
// ---------------------------------------------------------------------------
module seg_hex_glyph
   import seg_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] glyph
);

   // Hex digit lookup.
   always_comb begin
      glyph = SEG_OFF;
      case (nibble)
         4'h0:    glyph = GLYPH_0;
         4'h1:    glyph = GLYPH_1;
         4'h2:    glyph = GLYPH_2;
         4'h3:    glyph = GLYPH_3;
         4'h4:    glyph = GLYPH_4;
         4'h5:    glyph = GLYPH_5;
         4'h6:    glyph = GLYPH_6;
         4'h7:    glyph = GLYPH_7;
         4'h8:    glyph = GLYPH_8;
         4'h9:    glyph = GLYPH_9;
         4'hA:    glyph = GLYPH_A;
         4'hB:    glyph = GLYPH_B;
         4'hC:    glyph = GLYPH_C;
         4'hD:    glyph = GLYPH_D;
         4'hE:    glyph = GLYPH_E;
         4'hF:    glyph = GLYPH_F;
         default: glyph = SEG_OFF;
      endcase
   end

endmodule : seg_hex_glyph

// File: rtl/seg_scan_driver.sv
// ---------------------------------------------------------------------------
// seg_scan_driver
// Time-multiplexed driver for NUM_DIGITS 7-segment digits on a shared bus.
// A shadow register holds the displayed word; one digit is scanned per slot
// of CLK_DIV cycles, the first DEAD_CYCLES of each slot fully dark.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   load         capture value/dp_in/blank_in into the shadow register
//   value        packed nibbles, digit 0 = bits [3:0]
//   dp_in        decimal point request per digit
//   blank_in     per-digit forced dark
//   lz_suppress  live leading-zero blanking enable
//   seg, dp, an  registered pin drives (polarity set by parameters)
//   frame_tick   1-cycle pulse when the scan index wraps to digit 0
// ---------------------------------------------------------------------------
module seg_scan_driver
   import seg_pkg::*;
#(
   parameter int NUM_DIGITS     = 4,
   parameter int CLK_DIV        = 50000,
   parameter int DEAD_CYCLES    = 16,
   parameter int SEG_ACTIVE_LOW = 1,
   parameter int AN_ACTIVE_LOW  = 1
)(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic [NUM_DIGITS-1:0]   blank_in,
   input  logic                    lz_suppress,
   output logic [6:0]              seg,
   output logic                    dp,
   output logic [NUM_DIGITS-1:0]   an,
   output logic                    frame_tick
);

   localparam int IW = clog2_min1(NUM_DIGITS);
   localparam int PW = clog2_min1(CLK_DIV);

   // XOR masks turn active-high internal levels into pin polarity.
   localparam logic [6:0]            SEG_XOR = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
   localparam logic                  DP_XOR  = (SEG_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
   localparam logic [NUM_DIGITS-1:0] AN_XOR  = (AN_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}}
                                                                    : {NUM_DIGITS{1'b0}};

   logic [PW-1:0]           presc_r;
   logic [IW-1:0]           idx_r;
   logic [4*NUM_DIGITS-1:0] sh_val_r;
   logic [NUM_DIGITS-1:0]   sh_dp_r;
   logic [NUM_DIGITS-1:0]   sh_blank_r;
   logic [6:0]              seg_r;
   logic                    dp_r;
   logic [NUM_DIGITS-1:0]   an_r;
   logic                    frame_tick_r;

   logic                    tick_s;
   logic                    dead_s;
   logic [3:0]              nib_s;
   logic                    dp_sel_s;
   logic                    blank_sel_s;
   logic                    lz_sel_s;
   logic                    zero_run_s;
   logic [NUM_DIGITS-1:0]   zero_above_s;
   logic [NUM_DIGITS-1:0]   an_sel_s;
   logic                    lit_s;
   logic [6:0]              glyph_s;
   logic [6:0]              seg_hi_s;
   logic                    dp_hi_s;
   logic [NUM_DIGITS-1:0]   an_hi_s;

   assign tick_s = (presc_r == PW'(CLK_DIV - 1));
   assign dead_s = (int'(presc_r) < DEAD_CYCLES);

   // Select the current digit's shadow data and its leading-zero status.
   always_comb begin
      nib_s        = 4'h0;
      dp_sel_s     = 1'b0;
      blank_sel_s  = 1'b0;
      lz_sel_s     = 1'b0;
      an_sel_s     = {NUM_DIGITS{1'b0}};
      zero_above_s = {NUM_DIGITS{1'b0}};
      zero_run_s   = 1'b1;
      // zero_above_s[i]: nibbles i..NUM_DIGITS-1 are all zero.
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         zero_run_s      = zero_run_s & (sh_val_r[4*i +: 4] == 4'h0);
         zero_above_s[i] = zero_run_s;
      end
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx_r == IW'(i)) begin
            an_sel_s[i] = 1'b1;
            nib_s       = sh_val_r[4*i +: 4];
            dp_sel_s    = sh_dp_r[i];
            blank_sel_s = sh_blank_r[i];
            lz_sel_s    = (i > 0) && zero_above_s[i];
         end else begin
            an_sel_s[i] = 1'b0;
         end
      end
   end

   seg_hex_glyph u_glyph (
      .nibble (nib_s),
      .glyph  (glyph_s)
   );

   // Lit decision and active-high pin values for the current slot.
   always_comb begin
      lit_s    = !dead_s && !blank_sel_s && !(lz_suppress && lz_sel_s);
      seg_hi_s = lit_s ? glyph_s : SEG_OFF;
      dp_hi_s  = lit_s && dp_sel_s;
      an_hi_s  = lit_s ? an_sel_s : {NUM_DIGITS{1'b0}};
   end

   // Slot prescaler, scan index and frame pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         presc_r      <= {PW{1'b0}};
         idx_r        <= {IW{1'b0}};
         frame_tick_r <= 1'b0;
      end else begin
         frame_tick_r <= tick_s && (idx_r == IW'(NUM_DIGITS - 1));
         if (tick_s) begin
            presc_r <= {PW{1'b0}};
            if (idx_r == IW'(NUM_DIGITS - 1)) begin
               idx_r <= {IW{1'b0}};
            end else begin
               idx_r <= idx_r + IW'(1);
            end
         end else begin
            presc_r <= presc_r + PW'(1);
         end
      end
   end

   // Shadow register for the displayed word.
   always_ff @(posedge clk) begin
      if (rst) begin
         sh_val_r   <= {(4*NUM_DIGITS){1'b0}};
         sh_dp_r    <= {NUM_DIGITS{1'b0}};
         sh_blank_r <= {NUM_DIGITS{1'b0}};
      end else if (load) begin
         sh_val_r   <= value;
         sh_dp_r    <= dp_in;
         sh_blank_r <= blank_in;
      end
   end

   // Registered pin drives with polarity applied.
   always_ff @(posedge clk) begin
      if (rst) begin
         seg_r <= SEG_OFF ^ SEG_XOR;
         dp_r  <= DP_XOR;
         an_r  <= AN_XOR;
      end else begin
         seg_r <= seg_hi_s ^ SEG_XOR;
         dp_r  <= dp_hi_s ^ DP_XOR;
         an_r  <= an_hi_s ^ AN_XOR;
      end
   end

   assign seg        = seg_r;
   assign dp         = dp_r;
   assign an         = an_r;
   assign frame_tick = frame_tick_r;

endmodule : seg_scan_driver
